// File: rtl/pipe_reg_chain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_reg_chain                                               |
// | Description : Parametrised multi-stage pipeline register chain with        |
// |               per-stage valid, backward stall propagation, per-stage       |
// |               flush and NOP bubble insertion.                              |
// |               Optional statistics counters: PIPE_REG_CHAIN_STATS_EN        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pipe_reg_chain #(
  parameter int          WIDTH       = 32,
  parameter int          STAGES      = 3,
  parameter logic [31:0] FLUSH_VALUE = 32'h00000013,
  parameter int          CNT_W       = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [STAGES-1:0] stall,
  input  logic [STAGES-1:0] flush,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  output logic [STAGES-1:0] stage_valid,
  output logic [CNT_W-1:0]  occupancy
`ifdef PIPE_REG_CHAIN_STATS_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_kills
`endif
);

  // Bubble payload: FLUSH_VALUE truncated or zero-extended to the payload width
  localparam logic [WIDTH-1:0] C_FLUSH = WIDTH'(FLUSH_VALUE);

  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [CNT_W-1:0]  occ_q;
  logic [CNT_W-1:0]  occ_d;

  logic [STAGES-1:0] w_hold;
  logic [WIDTH-1:0]  w_pre_data [STAGES];
  logic [STAGES-1:0] w_pre_valid;
  logic              w_acc;

  // A stall on stage j holds stage j and everything upstream of it
  always_comb begin
    w_acc  = 1'b0;
    w_hold = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      w_acc     = w_acc | stall[i];
      w_hold[i] = w_acc;
    end
  end

  assign in_ready = ~w_hold[0];

  // Pre-flush entry of each stage (hold / load / bubble / advance), then flush override
  always_comb begin
    w_pre_data[0]  = data_q[0];
    w_pre_valid[0] = valid_q[0];
    if (!w_hold[0]) begin
      w_pre_valid[0] = in_valid;
      w_pre_data[0]  = in_valid ? in_data : C_FLUSH;
    end
    for (int i = 1; i < STAGES; i++) begin
      w_pre_data[i]  = data_q[i];
      w_pre_valid[i] = valid_q[i];
      if (!w_hold[i]) begin
        if (w_hold[i-1]) begin
          // Upstream is held but this stage moves on: insert a NOP bubble
          w_pre_data[i]  = C_FLUSH;
          w_pre_valid[i] = 1'b0;
        end else begin
          w_pre_data[i]  = data_q[i-1];
          w_pre_valid[i] = valid_q[i-1];
        end
      end
    end
    for (int i = 0; i < STAGES; i++) begin
      data_d[i]  = flush[i] ? C_FLUSH : w_pre_data[i];
      valid_d[i] = flush[i] ? 1'b0    : w_pre_valid[i];
    end
  end

  // Occupancy tracks the popcount of the valid bits being loaded
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < STAGES; i++) begin
      occ_d = occ_d + CNT_W'(valid_d[i]);
    end
  end

  // Stage registers; reset dominates stall and flush
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= C_FLUSH;
      end
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= data_d[i];
      end
      valid_q <= valid_d;
      occ_q   <= occ_d;
    end
  end

  assign out_data    = data_q[STAGES-1];
  assign out_valid   = valid_q[STAGES-1];
  assign stage_valid = valid_q;
  assign occupancy   = occ_q;

`ifdef PIPE_REG_CHAIN_STATS_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] stall_cycles_d;
  logic [31:0] flush_kills_q;
  logic [31:0] flush_kills_d;
  logic [31:0] w_kill_cnt;
  logic [32:0] w_kill_sum;

  // Saturating counters: rejected valid inputs and valid entries squashed by flush
  always_comb begin
    w_kill_cnt = '0;
    for (int i = 0; i < STAGES; i++) begin
      w_kill_cnt = w_kill_cnt + 32'(flush[i] & w_pre_valid[i]);
    end
    w_kill_sum     = {1'b0, flush_kills_q} + {1'b0, w_kill_cnt};
    flush_kills_d  = w_kill_sum[32] ? 32'hFFFF_FFFF : w_kill_sum[31:0];
    stall_cycles_d = stall_cycles_q;
    if (in_valid && !in_ready && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_kills_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_kills_q  <= flush_kills_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_kills  = flush_kills_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_reg_chain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pipe_reg_chain                                            |
// | Description : Scoreboard bench for pipe_reg_chain (WIDTH=32, STAGES=3).    |
// |               Statistics checks are built when PIPE_REG_CHAIN_STATS_EN set.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pipe_reg_chain;

  localparam int          WIDTH  = 32;
  localparam int          STAGES = 3;
  localparam int          CNT_W  = $clog2(STAGES + 1);
  localparam logic [31:0] C_NOP  = 32'h00000013;

  logic              clk = 1'b0;
  logic              rst;
  logic [WIDTH-1:0]  in_data;
  logic              in_valid;
  logic              in_ready;
  logic [STAGES-1:0] stall;
  logic [STAGES-1:0] flush;
  logic [WIDTH-1:0]  out_data;
  logic              out_valid;
  logic [STAGES-1:0] stage_valid;
  logic [CNT_W-1:0]  occupancy;
`ifdef PIPE_REG_CHAIN_STATS_EN
  logic [31:0]       stall_cycles;
  logic [31:0]       flush_kills;
`endif

  pipe_reg_chain #(
    .WIDTH      (WIDTH),
    .STAGES     (STAGES),
    .FLUSH_VALUE(C_NOP),
    .CNT_W      (CNT_W)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .stall      (stall),
    .flush      (flush),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .stage_valid(stage_valid),
    .occupancy  (occupancy)
`ifdef PIPE_REG_CHAIN_STATS_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_kills (flush_kills)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    bit          chk_lat;
  } sb_t;

  sb_t  sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic last_out_stall = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word; it is expected at the output only if accepted this cycle
  task automatic send(input logic [31:0] d, input bit lat);
    sb_t e;
    in_data  = d;
    in_valid = 1'b1;
    #1;
    if (in_ready) begin
      e.data    = d;
      e.cyc     = cyc;
      e.chk_lat = lat;
      sb_q.push_back(e);
    end
    tick();
  endtask

  task automatic idle_tick();
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
    tick();
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    stall    = '0;
    flush    = '0;
    n = 0;
    while ((occupancy != 0 || sb_q.size() != 0) && n < 20) begin
      tick();
      n++;
    end
    check("drain_occ", 32'(occupancy), 32'd0);
    check("drain_sb", 32'(sb_q.size()), 32'd0);
  endtask

  // The last stage loads a new entry on every edge where it is not stalled
  always @(posedge clk) begin
    cyc++;
    last_out_stall = stall[STAGES-1];
  end

  always @(negedge clk) begin
    sb_t e;
    if (out_valid && !last_out_stall) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_out", out_data, 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        check("sb_data", out_data, e.data);
        if (e.chk_lat) check("latency", 32'(cyc - e.cyc), 32'(STAGES));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int occ_exp [6] = '{1, 2, 3, 2, 1, 0};

    rst      = 1'b1;
    in_data  = '0;
    in_valid = 1'b0;
    stall    = '0;
    flush    = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_stage_valid", 32'(stage_valid), 32'd0);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_out_data", out_data, C_NOP);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Streaming 0x11, 0x22, 0x33 and drain
    for (int i = 0; i < 6; i++) begin
      if (i < 3) send(32'h11 * (i + 1), 1'b1);
      else       idle_tick();
      check("stream_occ", 32'(occupancy), 32'(occ_exp[i]));
    end
    drain();

    // Back-pressure: full chain, stall on last stage for two cycles
    send(32'hA0, 1'b0);
    send(32'hB0, 1'b0);
    send(32'hC0, 1'b0);
    stall = 3'b100;
    for (int i = 0; i < 2; i++) begin
      send(32'hD0, 1'b0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_stage_valid", 32'(stage_valid), 32'b111);
      check("bp_out_data", out_data, 32'hA0);
    end
    drain();

    // Bubble: stall stage 0 for one cycle in a full stream
    send(32'hE0, 1'b0);
    send(32'hE1, 1'b0);
    send(32'hE2, 1'b0);
    stall = 3'b001;
    send(32'hE3, 1'b0);
    check("bub_stage_valid", 32'(stage_valid), 32'b101);
    check("bub_occ", 32'(occupancy), 32'd2);
    stall = 3'b000;
    send(32'hE3, 1'b0);
    check("bub_out_valid_gap", 32'(out_valid), 32'd0);
    check("bub_out_data_gap", out_data, C_NOP);
    drain();

    // Flush beats stall on stage 1
    send(32'hF0, 1'b0);
    send(32'hF1, 1'b0);
    send(32'hF2, 1'b0);
    stall = 3'b111;
    flush = 3'b010;
    send(32'hF3, 1'b0);
    sb_q.delete(0);
    check("fl_stage_valid", 32'(stage_valid), 32'b101);
    check("fl_occ", 32'(occupancy), 32'd2);
    check("fl_out_data", out_data, 32'hF0);
    stall = '0;
    flush = '0;
    idle_tick();
    check("fl_bubble_valid", 32'(out_valid), 32'd0);
    check("fl_bubble_data", out_data, C_NOP);
    drain();

    // Reset mid-operation on a full chain
    send(32'h50, 1'b0);
    send(32'h51, 1'b0);
    send(32'h52, 1'b0);
    rst = 1'b1;
    send(32'h53, 1'b0);
    sb_q.delete();
    rst = 1'b0;
    check("mrst_stage_valid", 32'(stage_valid), 32'd0);
    check("mrst_occ", 32'(occupancy), 32'd0);
    check("mrst_out_data", out_data, C_NOP);
    idle_tick();
    check("mrst_ignored", 32'(occupancy), 32'd0);

`ifdef PIPE_REG_CHAIN_STATS_EN
    check("st_rst_stall", stall_cycles, 32'd0);
    check("st_rst_kills", flush_kills, 32'd0);
    send(32'h60, 1'b0);
    send(32'h61, 1'b0);
    send(32'h62, 1'b0);
    stall = 3'b100;
    for (int i = 0; i < 3; i++) send(32'h63, 1'b0);
    in_valid = 1'b0;
    flush    = 3'b111;
    tick();
    sb_q.delete();
    check("st_stall_cycles", stall_cycles, 32'd3);
    check("st_flush_kills", flush_kills, 32'd3);
    check("st_empty", 32'(stage_valid), 32'd0);
    stall = '0;
    flush = '0;
`endif

    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
